display_select_ctrl: RTL and testbench
======================================

DISPLAY_SELECT_CTRL -- requirements
Module: display_select_ctrl

Interface
REQ-001 Parameter HOLD_FRAMES, default 120: minimum frames shown before an auto-mode switch is allowed.
REQ-002 Parameter ALT_FRAMES, default 300: frames per player in alternate mode.
REQ-003 Parameter CNT_W, default 9: frame counter width; SHALL hold max(HOLD_FRAMES, ALT_FRAMES).
REQ-004 clk_sys  in  1  system clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 vid1  in  1  player-1 monochrome video.
REQ-007 vid2  in  1  player-2 monochrome video.
REQ-008 vblank  in  1  vertical blank, active high, synchronous to clk_sys.
REQ-009 mode  in  2  00 = fixed P1; 01 = fixed P2; 10 = auto (follow active player); 11 = alternate.
REQ-010 act1  in  1  player-1 activity, level: any P1 control pressed.
REQ-011 act2  in  1  player-2 activity, level.
REQ-012 vid_out  out  1  selected video, registered.
REQ-013 sel  out  1  displayed player: 0 = P1, 1 = P2.
REQ-014 switch_pulse  out  1  one-cycle pulse on the cycle sel changes.

Function
REQ-015 Frame tick SHALL be the 0->1 edge of vblank, detected against a registered copy of vblank; at most one tick per vblank period.
REQ-016 FSM states: SHOW_P1, PEND_P2, SHOW_P2, PEND_P1. sel = 0 in SHOW_P1 and PEND_P2; sel = 1 in SHOW_P2 and PEND_P1.
REQ-017 Switch request, evaluated every cycle in SHOW_x: fixed modes request when sel differs from the mode's player; auto requests when only the other player's act is high and frame_cnt >= HOLD_FRAMES; alternate requests when frame_cnt >= ALT_FRAMES.
REQ-018 SHOW_P1 -> PEND_P2 on request; SHOW_P2 -> PEND_P1 on request.
REQ-019 PEND_x SHALL complete on the next frame tick: go to SHOW_x, toggle sel, assert switch_pulse for that cycle, clear frame_cnt to 0.
REQ-020 A request and a tick in the same cycle in SHOW_x SHALL enter PEND_x only; the switch happens on the following tick. Switches therefore occur only at vblank onset.
REQ-021 In PEND_x, when the request no longer holds (mode change, or auto with act1 = act2 = 1), the FSM SHALL return to SHOW_ of the current player without toggling sel.
REQ-022 In auto mode, act1 = act2 = 1 SHALL produce no request; the current player is kept.
REQ-023 frame_cnt SHALL increment on every tick that does not cause a switch, and SHALL saturate at 2^CNT_W - 1 (no wrap).
REQ-024 vid_out SHALL equal (sel ? vid2 : vid1) registered: latency 1 clk_sys cycle. The sel used is the value before any same-cycle toggle.
REQ-025 A mode change SHALL neither reset frame_cnt nor switch immediately; the new mode's rule applies from the next cycle.

Reset
REQ-026 On reset assertion (asynchronous), all outputs and state SHALL take these values immediately and hold them while reset is high: state SHOW_P1, sel = 0, vid_out = 0, switch_pulse = 0, frame_cnt = 0, registered vblank = 0.
REQ-027 Reset deassertion during vblank high SHALL NOT produce a tick until vblank falls and rises again.

Structure
REQ-028 Package subs_pkg SHALL hold the FSM state enum and the mode encodings MODE_P1, MODE_P2, MODE_AUTO, MODE_ALT.
REQ-029 One sub-module, vblank_frame_tick, SHALL contain the vblank edge detector and the saturating frame counter with a synchronous clear input.
REQ-030 No clock gating or derived clocks; the design is sized for about 150-250 lines of RTL.

Verification
REQ-031 Reset then mode = 00, vid1 = 1, vid2 = 0 -> sel = 0; vid_out = 1 one cycle after reset release; switch_pulse is never asserted.
REQ-032 mode 00 -> 01 in mid-frame -> sel stays 0 until the next vblank rise; on that cycle sel = 1, switch_pulse is high for 1 cycle, and frame_cnt = 0.
REQ-033 Auto mode, HOLD_FRAMES = 4, act2 = 1 from frame 1 -> switch occurs at the tick after frame_cnt reaches 4, never earlier.
REQ-034 Auto mode, act1 = act2 = 1 for 500 frames -> no switch; act1 = 1 during PEND_P2 -> return to SHOW_P1 with sel = 0.
REQ-035 Alternate mode, ALT_FRAMES = 3 -> sel toggles on every 4th tick (3 counted ticks, then the switching tick); pattern repeats 10 times.
REQ-036 Reset asserted in PEND_P2 while vblank = 1 -> sel = 0 immediately; no tick after release until a fresh vblank rise; counter saturation checked with CNT_W = 3 (frame_cnt holds at 7).

Source files
------------

// File: rtl/display_select_ctrl_pkg.sv
// subs_pkg: FSM state and mode encodings shared by the display select slice
package subs_pkg;
  typedef enum logic [1:0] {SHOW_P1, PEND_P2, SHOW_P2, PEND_P1} state_t;
  typedef enum logic [1:0] {MODE_P1 = 2'b00, MODE_P2 = 2'b01, MODE_AUTO = 2'b10, MODE_ALT = 2'b11} mode_t;
endpackage

// File: rtl/display_select_ctrl_if.sv
// display_select_ctrl_if: video, vblank, mode and activity in; selected video and status out
interface display_select_ctrl_if;
  import subs_pkg::*;
  logic vid1, vid2, vblank, act1, act2, vid_out, sel, switch_pulse;
  mode_t mode;
  modport master (output vid1, vid2, vblank, mode, act1, act2, input vid_out, sel, switch_pulse);
  modport slave (input vid1, vid2, vblank, mode, act1, act2, output vid_out, sel, switch_pulse);
endinterface

// File: rtl/display_select_ctrl_vblank_frame_tick.sv
// vblank_frame_tick: vblank onset detector and saturating frame counter with sync clear
module vblank_frame_tick #(
  parameter int CNT_W = 9
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             vblank,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] frame_cnt
);
  logic vblank_q, armed;
  // armed needs vblank seen low after reset, so a vblank already high at release never ticks
  assign tick = vblank & ~vblank_q & armed;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      vblank_q  <= 1'b0;
      armed     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vblank_q  <= vblank;
      armed     <= armed | ~vblank;
      frame_cnt <= clr ? '0 : (tick && !(&frame_cnt)) ? frame_cnt + 1'b1 : frame_cnt;
    end
endmodule

// File: rtl/display_select_ctrl.sv
// display_select_ctrl: picks player-1/player-2 video, switching only at vblank onset
module display_select_ctrl
  import subs_pkg::*;
#(
  parameter int HOLD_FRAMES = 120,
  parameter int ALT_FRAMES  = 300,
  parameter int CNT_W       = 9
) (
  input logic               clk_sys,
  input logic               reset,
  display_select_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] ALT_C  = CNT_W'(ALT_FRAMES);
  state_t state;
  logic tick, req, sw, own_act, other_act;
  logic [CNT_W-1:0] frame_cnt;
  vblank_frame_tick #(.CNT_W(CNT_W)) u_tick (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vblank    (bus.vblank),
    .clr       (sw),
    .tick      (tick),
    .frame_cnt (frame_cnt)
  );
  always_comb begin
    own_act   = bus.sel ? bus.act2 : bus.act1;
    other_act = bus.sel ? bus.act1 : bus.act2;
    req = bus.mode == MODE_P1   ? bus.sel :
          bus.mode == MODE_P2   ? ~bus.sel :
          bus.mode == MODE_AUTO ? other_act & ~own_act & (frame_cnt >= HOLD_C) :
                                  frame_cnt >= ALT_C;
    sw = (state == PEND_P2 || state == PEND_P1) & req & tick;
  end
  // a pending switch is abandoned as soon as the request drops, even on a tick cycle
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state            <= SHOW_P1;
      bus.sel          <= 1'b0;
      bus.vid_out      <= 1'b0;
      bus.switch_pulse <= 1'b0;
    end else begin
      bus.vid_out      <= bus.sel ? bus.vid2 : bus.vid1;
      bus.switch_pulse <= sw;
      if (sw) bus.sel <= ~bus.sel;
      case (state)
        SHOW_P1: if (req) state <= PEND_P2;
        SHOW_P2: if (req) state <= PEND_P1;
        PEND_P2: state <= !req ? SHOW_P1 : tick ? SHOW_P2 : PEND_P2;
        PEND_P1: state <= !req ? SHOW_P2 : tick ? SHOW_P1 : PEND_P1;
      endcase
    end
endmodule

// File: tb/tb_display_select_ctrl.sv
// tb_display_select_ctrl: vector table, directed corner sequences and randomized frames vs a reference model
module tb_display_select_ctrl;
  import subs_pkg::*;
  localparam int HOLD = 4, ALT = 3, CW = 3, CMAX = (1 << CW) - 1;
  logic clk_sys = 1'b0, reset = 1'b0;
  display_select_ctrl_if bus();
  display_select_ctrl #(.HOLD_FRAMES(HOLD), .ALT_FRAMES(ALT), .CNT_W(CW)) u_dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit vid1, vid2, vblank;
    mode_t mode;
    bit act1, act2, e_sel, e_vid, e_pls;
    int e_cnt;
  } vec_t;
  vec_t tbl[10];

  int vectors = 0, miscompares = 0;
  int ticks, pulses, first_pulse_tick;
  bit m_player, m_pending, m_prev_vb, m_vid, m_pulse;
  int m_cnt;

  // expected behaviour from the selection rules: who is shown, whether a switch waits for vblank
  function automatic bit wants_switch();
    bit own, other;
    own   = m_player ? bus.act2 : bus.act1;
    other = m_player ? bus.act1 : bus.act2;
    case (bus.mode)
      MODE_P1:   return m_player;
      MODE_P2:   return !m_player;
      MODE_AUTO: return other && !own && m_cnt >= HOLD;
      default:   return m_cnt >= ALT;
    endcase
  endfunction

  task automatic model_reset();
    m_player = 0; m_pending = 0; m_prev_vb = 1; m_vid = 0; m_pulse = 0; m_cnt = 0;
    ticks = 0; pulses = 0; first_pulse_tick = -1;
  endtask

  task automatic model_step();
    bit tick, want, sw;
    tick = bus.vblank && !m_prev_vb;
    m_prev_vb = bus.vblank;
    want = wants_switch();
    sw = m_pending && want && tick;
    m_vid = m_player ? bus.vid2 : bus.vid1;
    m_pulse = sw;
    m_pending = want && !sw;
    m_cnt = sw ? 0 : (tick && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    if (sw) m_player = !m_player;
    if (tick) ticks++;
  endtask

  task automatic check_vec(string name, bit sel_e, bit vid_e, bit pls_e, int cnt_e);
    vectors++;
    if (bus.sel !== sel_e || bus.vid_out !== vid_e || bus.switch_pulse !== pls_e || u_dut.frame_cnt !== CW'(cnt_e)) begin
      miscompares++;
      $display("FAIL %s: got sel=%b vid=%b pulse=%b cnt=%0d, want sel=%b vid=%b pulse=%b cnt=%0d",
               name, bus.sel, bus.vid_out, bus.switch_pulse, u_dut.frame_cnt, sel_e, vid_e, pls_e, cnt_e);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step(string name);
    @(posedge clk_sys);
    model_step();
    #1;
    if (bus.switch_pulse) begin
      if (pulses == 0) first_pulse_tick = ticks;
      pulses++;
    end
    check_vec(name, m_player, m_vid, m_pulse, m_cnt);
  endtask

  task automatic frame(string name, int lo, int hi);
    repeat (lo) begin bus.vblank = 0; step(name); end
    repeat (hi) begin bus.vblank = 1; step(name); end
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    #1;
    check_vec("reset_async", 0, 0, 0, 0);
    repeat (2) @(posedge clk_sys);
    #1;
    check_vec("reset_hold", 0, 0, 0, 0);
    reset = 0;
  endtask

  task automatic drive(bit vb, mode_t md, bit a1, bit a2);
    bus.vblank = vb; bus.mode = md; bus.act1 = a1; bus.act2 = a2;
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, MODE_P1, 0, 0, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, MODE_P1, 0, 0, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 1, MODE_P1, 0, 0, 0, 1, 0, 1};
    tbl[3] = '{1, 0, 1, MODE_P1, 0, 0, 0, 1, 0, 1};
    tbl[4] = '{1, 0, 0, MODE_P1, 0, 0, 0, 1, 0, 1};
    tbl[5] = '{1, 0, 0, MODE_P2, 0, 0, 0, 1, 0, 1};
    tbl[6] = '{0, 1, 0, MODE_P2, 0, 0, 0, 0, 0, 1};
    tbl[7] = '{0, 1, 1, MODE_P2, 0, 0, 1, 0, 1, 0};
    tbl[8] = '{0, 1, 1, MODE_P2, 0, 0, 1, 1, 0, 0};
    tbl[9] = '{0, 1, 0, MODE_P2, 0, 0, 1, 1, 0, 0};
    bus.vid1 = 1; bus.vid2 = 0;
    drive(0, MODE_P1, 0, 0);
    #2;
    do_reset();
    foreach (tbl[i]) begin
      bus.vid1 = tbl[i].vid1; bus.vid2 = tbl[i].vid2;
      drive(tbl[i].vblank, tbl[i].mode, tbl[i].act1, tbl[i].act2);
      @(posedge clk_sys);
      #1;
      check_vec($sformatf("tbl%0d", i), tbl[i].e_sel, tbl[i].e_vid, tbl[i].e_pls, tbl[i].e_cnt);
    end

    // auto: player 2 active from the first frame, switch waits for HOLD counted frames
    drive(0, MODE_AUTO, 0, 1);
    do_reset();
    repeat (8) frame("auto_hold", 2, 2);
    check_int("auto_hold_tick", first_pulse_tick, HOLD + 1);
    check_int("auto_hold_count", pulses, 1);

    // auto with both players active never switches; cancel while pending
    drive(0, MODE_AUTO, 1, 1);
    do_reset();
    repeat (500) frame("auto_both", 2, 2);
    check_int("auto_both_nosw", pulses, 0);
    bus.act1 = 0;
    step("auto_pend");
    check_int("auto_pend_state", int'(u_dut.state), int'(PEND_P2));
    bus.act1 = 1;
    step("auto_cancel");
    check_int("auto_cancel_state", int'(u_dut.state), int'(SHOW_P1));
    frame("auto_cancel", 1, 2);
    check_int("auto_cancel_nosw", pulses, 0);

    // alternate: every 4th tick switches
    drive(0, MODE_ALT, 0, 0);
    do_reset();
    for (int f = 0; f < 40; f++) begin
      frame("alt", 2, 1);
      check_int("alt_pulses", pulses, ticks / 4);
    end
    check_int("alt_last", first_pulse_tick >= 0 ? ticks : -1, 40);

    // reset while pending with vblank high; no tick until a fresh rise
    drive(0, MODE_P2, 0, 0);
    bus.vid1 = 0; bus.vid2 = 1;
    do_reset();
    step("r36_pend");
    bus.vblank = 1;
    do_reset();
    repeat (3) step("r36_high");
    check_int("r36_notick", pulses, 0);
    frame("r36_fresh", 1, 2);
    check_int("r36_switch", pulses, 1);
    do_reset();

    // counter saturates rather than wrapping
    drive(0, MODE_P1, 0, 0);
    repeat (10) frame("sat", 1, 1);
    check_int("sat_cnt", int'(u_dut.frame_cnt), CMAX);

    // randomized frames, modes and activity
    do_reset();
    for (int f = 0; f < 600; f++) begin
      int lo, hi;
      if ($urandom_range(0, 3) == 0) bus.mode = mode_t'(2'($urandom_range(0, 3)));
      lo = $urandom_range(1, 5);
      hi = $urandom_range(1, 3);
      for (int c = 0; c < lo + hi; c++) begin
        bus.vblank = c >= lo;
        bus.vid1 = 1'($urandom);
        bus.vid2 = 1'($urandom);
        if ($urandom_range(0, 7) == 0) bus.act1 = 1'($urandom);
        if ($urandom_range(0, 7) == 0) bus.act2 = 1'($urandom);
        step("rand");
      end
      if (f % 150 == 149) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
